// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON permutation core: UNROLL chained rounds per clock,
// run-time round count 0..12 (larger requests clamp to 12).
module ascon_permutation_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic [319:0] in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [319:0] out
);

    if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
        $error("ascon_permutation_iter: UNROLL must be in 1..4");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        fsm;
    logic [319:0]  st;
    logic [3:0]    rc_idx;
    logic [3:0]    remaining;
    logic [3:0]    a_eff;
    logic [3:0]    step;
    logic [319:0]  chain;
    logic [319:0]  result;

    // 64-bit rotate right by a constant amount
    function automatic logic [63:0] ror(
        input logic [63:0] x,
        input int unsigned n
    );
        return (x >> n) | (x << (64 - n));
    endfunction

    // One full ASCON round with round-constant index r
    function automatic logic [319:0] round_fn(
        input logic [319:0] s,
        input logic [3:0]   r
    );
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];

        // constant addition: high nibble is 15-r, which is ~r in 4 bits
        x2 = x2 ^ {56'd0, ~r, r};

        // bitsliced 5-bit S-box
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        // linear diffusion
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);

        return {x0, x1, x2, x3, x4};
    endfunction

    // clamp requested round count to 12
    assign a_eff = (rounds > 4'd12) ? 4'd12 : rounds;

    // handshake status follows the FSM directly
    assign ready = (fsm == IDLE);
    assign busy  = ~ready;

    // chained rounds; stages past the remaining count pass through
    always_comb begin
        step  = (remaining < 4'(UNROLL)) ? remaining : 4'(UNROLL);
        chain = st;
        for (int j = 0; j < UNROLL; j++) begin
            if (4'(j) < step) begin
                chain = round_fn(chain, rc_idx + 4'(j));
            end
        end
        result = chain;
    end

    // control FSM with registered state, counters and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            st        <= '0;
            rc_idx    <= '0;
            remaining <= '0;
            out       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (start) begin
                        if (a_eff == 4'd0) begin
                            out  <= in;
                            done <= 1'b1;
                        end else begin
                            st        <= in;
                            rc_idx    <= 4'd12 - a_eff;
                            remaining <= a_eff;
                            fsm       <= RUN;
                        end
                    end
                end
                RUN: begin
                    st        <= result;
                    rc_idx    <= rc_idx + step;
                    remaining <= remaining - step;
                    if (remaining == step) begin
                        out  <= result;
                        done <= 1'b1;
                        fsm  <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Testbench for ascon_permutation_iter: four instances (UNROLL 1..4)
// checked against a table-driven reference permutation.
module tb_ascon_permutation_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_r [4];
    logic [3:0]   rnd_r   [4];
    logic [319:0] din_r   [4];
    logic         ready_w [4];
    logic         busy_w  [4];
    logic         done_w  [4];
    logic [319:0] out_w   [4];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt [4] = '{0, 0, 0, 0};

    int sbox [32] = '{
        4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
        30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23
    };
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    localparam logic [319:0] VEC =
        320'h80400c0600000000_c82cbe1c72be1a3a_85621d92797f8475_23fd6519897d9e12_5c0609b2f5ca3aaa;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ascon_permutation_iter #(.UNROLL(g + 1)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_r[g]),
            .rounds (rnd_r[g]),
            .in     (din_r[g]),
            .ready  (ready_w[g]),
            .busy   (busy_w[g]),
            .done   (done_w[g]),
            .out    (out_w[g])
        );
    end

    always @(posedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (done_w[u] === 1'b1) done_cnt[u]++;
        end
    end

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // reference: S-box by table lookup per bit column
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int a_raw);
        logic [63:0] x [5];
        logic [63:0] y [5];
        int a;
        a = (a_raw > 12) ? 12 : a_raw;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int i = 0; i < a; i++) begin
            int r;
            r = 12 - a + i;
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                int v;
                int o;
                v = 0;
                for (int k = 0; k < 5; k++) v = v * 2 + int'(x[k][b]);
                o = sbox[v];
                for (int k = 0; k < 5; k++) y[k][b] = o[4 - k];
            end
            for (int k = 0; k < 5; k++)
                x[k] = y[k] ^ rotr(y[k], rot_a[k]) ^ rotr(y[k], rot_b[k]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int exp_lat(input int u, input int a_raw);
        int a;
        a = (a_raw > 12) ? 12 : a_raw;
        return (a == 0) ? 0 : (a + u) / (u + 1);
    endfunction

    // drive one operation; measure latency, busy cycles, result, pulse/hold
    task automatic run_op(input int u, input logic [3:0] r, input logic [319:0] d,
                          output int lat, output int bc,
                          output logic [319:0] res, output bit held);
        start_r[u] = 1'b1;
        rnd_r[u]   = r;
        din_r[u]   = d;
        @(posedge clk); #1;
        start_r[u] = 1'b0;
        rnd_r[u]   = 4'($urandom_range(0, 15));
        din_r[u]   = rand320();
        lat = 0;
        bc  = 0;
        while (done_w[u] !== 1'b1 && lat < 40) begin
            if (busy_w[u] === 1'b1) bc++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) lat = -1;
        res = out_w[u];
        @(posedge clk); #1;
        held = (done_w[u] === 1'b0) && (out_w[u] === res) && (ready_w[u] === 1'b1);
    endtask

    task automatic test_reset();
        for (int u = 0; u < 4; u++) begin
            n_tests++;
            if (ready_w[u] !== 1'b1 || busy_w[u] !== 1'b0 ||
                done_w[u] !== 1'b0 || out_w[u] !== 320'd0) begin
                n_fail++;
                $display("FAIL reset u%0d: ready=%b busy=%b done=%b out=%h want 1 0 0 0",
                         u + 1, ready_w[u], busy_w[u], done_w[u], out_w[u]);
            end
        end
    endtask

    task automatic test_golden();
        int lat, bc;
        logic [319:0] res;
        bit held;
        int avals [3] = '{12, 6, 8};
        for (int u = 0; u < 4; u++) begin
            for (int i = 0; i < 3; i++) begin
                run_op(u, 4'(avals[i]), VEC, lat, bc, res, held);
                n_tests++;
                if (res !== ref_perm(VEC, avals[i])) begin
                    n_fail++;
                    $display("FAIL golden_out u%0d a%0d: got %h want %h",
                             u + 1, avals[i], res, ref_perm(VEC, avals[i]));
                end
                n_tests++;
                if (lat != exp_lat(u, avals[i]) || bc != exp_lat(u, avals[i])) begin
                    n_fail++;
                    $display("FAIL golden_lat u%0d a%0d: lat=%0d busy=%0d want %0d",
                             u + 1, avals[i], lat, bc, exp_lat(u, avals[i]));
                end
                n_tests++;
                if (!held) begin
                    n_fail++;
                    $display("FAIL golden_pulse u%0d a%0d: held=%0d want 1", u + 1, avals[i], held);
                end
            end
        end
    endtask

    task automatic test_edge_rounds();
        int lat, bc;
        logic [319:0] res;
        bit held;
        logic [319:0] d;
        for (int u = 0; u < 4; u++) begin
            d = rand320();
            run_op(u, 4'd0, d, lat, bc, res, held);
            n_tests++;
            if (res !== d || lat != 0 || bc != 0 || !held) begin
                n_fail++;
                $display("FAIL zero_rounds u%0d: out=%h lat=%0d busy=%0d want %h 0 0",
                         u + 1, res, lat, bc, d);
            end
            run_op(u, 4'd15, VEC, lat, bc, res, held);
            n_tests++;
            if (res !== ref_perm(VEC, 12) || lat != exp_lat(u, 12) || !held) begin
                n_fail++;
                $display("FAIL clamp_rounds u%0d: out=%h lat=%0d want %h lat %0d",
                         u + 1, res, lat, ref_perm(VEC, 12), exp_lat(u, 12));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [319:0] da, db, ra, rb;
        int k;
        for (int u = 0; u < 4; u++) begin
            da = rand320();
            db = rand320();
            ra = ref_perm(da, 6);
            rb = ref_perm(db, 8);
            start_r[u] = 1'b1;
            rnd_r[u]   = 4'd6;
            din_r[u]   = da;
            @(posedge clk); #1;
            rnd_r[u] = 4'd8;
            din_r[u] = db;
            k = 0;
            while (done_w[u] !== 1'b1 && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            n_tests++;
            if (k != exp_lat(u, 6) || out_w[u] !== ra || ready_w[u] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_first u%0d: lat=%0d out=%h want lat %0d out %h",
                         u + 1, k, out_w[u], exp_lat(u, 6), ra);
            end
            @(posedge clk); #1;
            start_r[u] = 1'b0;
            n_tests++;
            if (busy_w[u] !== 1'b1 || done_w[u] !== 1'b0 || out_w[u] !== ra) begin
                n_fail++;
                $display("FAIL b2b_accept u%0d: busy=%b done=%b out=%h want 1 0 %h",
                         u + 1, busy_w[u], done_w[u], out_w[u], ra);
            end
            k = 0;
            while (done_w[u] !== 1'b1 && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            n_tests++;
            if (k != exp_lat(u, 8) || out_w[u] !== rb) begin
                n_fail++;
                $display("FAIL b2b_second u%0d: lat=%0d out=%h want lat %0d out %h",
                         u + 1, k, out_w[u], exp_lat(u, 8), rb);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        int snap, lat, bc;
        logic [319:0] res;
        bit held;
        snap = done_cnt[0];
        start_r[0] = 1'b1;
        rnd_r[0]   = 4'd12;
        din_r[0]   = VEC;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_w[0] !== 320'd0 || ready_w[0] !== 1'b1 ||
            busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: out=%h ready=%b busy=%b done=%b want 0 1 0 0",
                     out_w[0], ready_w[0], busy_w[0], done_w[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (16) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (done_cnt[0] != snap || out_w[0] !== 320'd0) begin
            n_fail++;
            $display("FAIL abort_no_done: pulses=%0d out=%h want 0 pulses out 0",
                     done_cnt[0] - snap, out_w[0]);
        end
        run_op(0, 4'd12, VEC, lat, bc, res, held);
        n_tests++;
        if (res !== ref_perm(VEC, 12) || lat != 12) begin
            n_fail++;
            $display("FAIL abort_restart: out=%h lat=%0d want %h lat 12",
                     res, lat, ref_perm(VEC, 12));
        end
    endtask

    task automatic test_random();
        int lat, bc, snap, nstart, r;
        logic [319:0] res, d;
        bit held;
        for (int u = 0; u < 4; u++) begin
            snap   = done_cnt[u];
            nstart = 0;
            for (int i = 0; i < 1000; i++) begin
                d = rand320();
                r = $urandom_range(0, 15);
                run_op(u, 4'(r), d, lat, bc, res, held);
                nstart++;
                n_tests++;
                if (res !== ref_perm(d, r) || lat != exp_lat(u, r) ||
                    bc != exp_lat(u, r) || !held) begin
                    n_fail++;
                    $display("FAIL random u%0d #%0d r%0d: out=%h lat=%0d busy=%0d held=%0d want %h lat %0d",
                             u + 1, i, r, res, lat, bc, held, ref_perm(d, r), exp_lat(u, r));
                end
            end
            @(posedge clk); #1;
            n_tests++;
            if (done_cnt[u] - snap != nstart) begin
                n_fail++;
                $display("FAIL random_count u%0d: done=%0d want %0d",
                         u + 1, done_cnt[u] - snap, nstart);
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            start_r[u] = 1'b0;
            rnd_r[u]   = 4'd0;
            din_r[u]   = 320'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_golden();
        test_edge_rounds();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
